// File: rtl/timer_mc_pkg.sv
// Shared register map, CTRL bit layout and channel types for the multi-channel timer.
package timer_mc_pkg;

    localparam logic [3:0] OFF_CTRL    = 4'h0;
    localparam logic [3:0] OFF_COUNT   = 4'h4;
    localparam logic [3:0] OFF_CMP     = 4'h8;
    localparam logic [7:0] ADDR_STATUS = 8'hF0;
    localparam logic [7:0] ADDR_PRESC  = 8'hF4;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_IE   = 1;
    localparam int CTRL_PEND = 2;
    localparam int CTRL_MODE = 3;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

    // Field order mirrors the CTRL register so the struct reads back directly.
    typedef struct packed {
        mode_e mode;
        logic  pend;
        logic  ie;
        logic  en;
    } ctrl_t;

endpackage

// File: rtl/timer_mc_chan.sv
// One timer channel: CTRL/COUNT/CMP state, compare hit, and set-beats-clear pending logic.
module timer_mc_chan
    import timer_mc_pkg::*;
#(
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          ctrl_we,
    input  logic          cmp_we,
    input  logic          clr,
    input  logic [31:0]   wdata,
    output ctrl_t         ctrl,
    output logic [CW-1:0] count,
    output logic [CW-1:0] cmp,
    output logic          irq
);

    logic hit;
    logic unused;

    // >= rather than == so lowering CMP below COUNT fires on the next tick instead of wrapping.
    assign hit    = ctrl.en & tick & (count >= cmp);
    assign irq    = ctrl.ie & ctrl.pend;
    assign unused = ^wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl  <= '0;
            count <= '0;
            cmp   <= '0;
        end else begin
            if (hit)
                count <= '0;
            else if (ctrl.en & tick)
                count <= count + CW'(1);
            else if (!ctrl.en)
                count <= '0;

            if (ctrl_we) begin
                ctrl.en   <= wdata[CTRL_EN];
                ctrl.ie   <= wdata[CTRL_IE];
                ctrl.mode <= mode_e'(wdata[CTRL_MODE]);
            end else if (hit && ctrl.mode == MODE_ONESHOT) begin
                ctrl.en <= 1'b0;
            end

            // A hit on the same edge as a software clear must not be lost.
            ctrl.pend <= (ctrl.pend & ~clr) | hit;

            if (cmp_we)
                cmp <= wdata[CW-1:0];
        end
    end

endmodule

// File: rtl/timer_mc.sv
// Multi-channel count-up timer on the simple periph bus: decode, read mux, prescaler, IRQ reduction.
// Optional shared prescaler at 0xF4 is built only when TIMER_MC_PRESCALER_EN is defined.
module timer_mc
    import timer_mc_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CW  = 32,
    parameter int PSW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    data_i,
    input  logic [31:0]    addr_i,
    input  logic           we_i,
    output logic [31:0]    data_o,
    output logic [NCH-1:0] int_ch_o,
    output logic           int_sig_o
);

    ctrl_t [NCH-1:0]          ctrls;
    logic  [NCH-1:0][CW-1:0]  counts;
    logic  [NCH-1:0][CW-1:0]  cmps;
    logic  [NCH-1:0]          ctrl_we, cmp_we, clr, pends, ens, irqs;
    logic                     sts_we, tick, unused;

    assign sts_we = we_i && (addr_i[7:0] == ADDR_STATUS);

    always_comb begin
        ctrl_we = '0;
        cmp_we  = '0;
        clr     = '0;
        for (int i = 0; i < NCH; i++) begin
            ctrl_we[i] = we_i && (addr_i[7:4] == 4'(i)) && (addr_i[3:0] == OFF_CTRL);
            cmp_we[i]  = we_i && (addr_i[7:4] == 4'(i)) && (addr_i[3:0] == OFF_CMP);
            clr[i]     = (ctrl_we[i] & data_i[CTRL_PEND]) | (sts_we & data_i[i]);
            pends[i]   = ctrls[i].pend;
            ens[i]     = ctrls[i].en;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        timer_mc_chan #(.CW(CW)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .tick    (tick),
            .ctrl_we (ctrl_we[g]),
            .cmp_we  (cmp_we[g]),
            .clr     (clr[g]),
            .wdata   (data_i),
            .ctrl    (ctrls[g]),
            .count   (counts[g]),
            .cmp     (cmps[g]),
            .irq     (irqs[g])
        );
    end

`ifdef TIMER_MC_PRESCALER_EN
    logic [PSW-1:0] presc, psc_cnt;
    logic           presc_we;

    assign presc_we = we_i && (addr_i[7:0] == ADDR_PRESC);
    assign tick     = (|ens) && (psc_cnt == presc);
    assign unused   = ^addr_i[31:8];

    // Held at zero while idle so the first tick after enable is a full PRESC+1 clks away.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc   <= '0;
            psc_cnt <= '0;
        end else begin
            if (presc_we)
                presc <= data_i[PSW-1:0];
            if (presc_we || !(|ens) || tick)
                psc_cnt <= '0;
            else
                psc_cnt <= psc_cnt + PSW'(1);
        end
    end
`else
    assign tick   = 1'b1;
    assign unused = ^{addr_i[31:8], ens, PSW[0]};
`endif

    always_comb begin
        data_o = '0;
        if (!rst) begin
            if (addr_i[7:0] == ADDR_STATUS)
                data_o = 32'(pends);
`ifdef TIMER_MC_PRESCALER_EN
            else if (addr_i[7:0] == ADDR_PRESC)
                data_o = 32'(presc);
`endif
            else
                for (int i = 0; i < NCH; i++)
                    if (addr_i[7:4] == 4'(i))
                        case (addr_i[3:0])
                            OFF_CTRL:  data_o = 32'(ctrls[i]);
                            OFF_COUNT: data_o = 32'(counts[i]);
                            OFF_CMP:   data_o = 32'(cmps[i]);
                            default:   data_o = '0;
                        endcase
        end
    end

    assign int_ch_o  = irqs;
    assign int_sig_o = |irqs;

endmodule

// File: tb/tb_timer_mc.sv
// Scoreboard bench for timer_mc: a per-register behavioural model predicts reads and IRQs each cycle.
module tb_timer_mc;

    localparam int NCH = 4;
    localparam int CW  = 32;
    localparam int PSW = 16;
    localparam longint CMASK = (longint'(1) << CW) - 1;

    logic           clk, rst, we_i, int_sig_o;
    logic [31:0]    data_i, addr_i, data_o;
    logic [NCH-1:0] int_ch_o;

    timer_mc #(.NCH(NCH), .CW(CW), .PSW(PSW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .addr_i    (addr_i),
        .we_i      (we_i),
        .data_o    (data_o),
        .int_ch_o  (int_ch_o),
        .int_sig_o (int_sig_o)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct { longint rd; int irq; } exp_t;
    exp_t q[$];
    int n_pass = 0, n_tot = 0;

    bit     m_en[NCH], m_ie[NCH], m_pend[NCH], m_mode[NCH];
    longint m_cnt[NCH], m_cmp[NCH];
    longint m_presc, m_psc;

    task automatic check(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NCH; i++) begin
            m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
            m_cnt[i] = 0; m_cmp[i] = 0;
        end
        m_presc = 0; m_psc = 0;
    endfunction

    function automatic longint m_read(input bit [7:0] a);
        int ch = int'(a >> 4);
        int off = int'(a & 8'h0F);
        longint r = 0;
        if (rst) return 0;
        if (a == 8'hF0) begin
            for (int i = 0; i < NCH; i++) if (m_pend[i]) r += longint'(1) << i;
            return r;
        end
        if (a == 8'hF4) begin
`ifdef TIMER_MC_PRESCALER_EN
            return m_presc;
`else
            return 0;
`endif
        end
        if (ch < NCH) begin
            if (off == 0) return m_en[ch] + 2 * m_ie[ch] + 4 * m_pend[ch] + 8 * m_mode[ch];
            if (off == 4) return m_cnt[ch];
            if (off == 8) return m_cmp[ch];
        end
        return 0;
    endfunction

    function automatic int m_irq();
        int r = 0;
        for (int i = 0; i < NCH; i++) if (m_ie[i] && m_pend[i]) r += 1 << i;
        return r;
    endfunction

    // Advance the model by one clock edge given this cycle's bus write.
    function automatic void m_step(input bit w, input bit [7:0] a, input bit [31:0] d);
        bit tk, any, pw;
        bit hit[NCH];
        int ch, off;
        if (rst) begin m_reset(); return; end
        any = 0;
        for (int i = 0; i < NCH; i++) any |= m_en[i];
        tk = 1;
`ifdef TIMER_MC_PRESCALER_EN
        tk = any && (m_psc == m_presc);
`endif
        for (int i = 0; i < NCH; i++) begin
            hit[i] = m_en[i] && tk && (m_cnt[i] >= m_cmp[i]);
            if (hit[i]) begin
                m_cnt[i] = 0;
                if (!m_mode[i]) m_en[i] = 0;
            end else if (m_en[i] && tk) m_cnt[i] = m_cnt[i] + 1;
            else if (!m_en[i]) m_cnt[i] = 0;
        end
        pw = 0;
        ch = int'(a >> 4);
        off = int'(a & 8'h0F);
        if (w) begin
            if (a == 8'hF0) begin
                for (int i = 0; i < NCH; i++) if (d[i]) m_pend[i] = 0;
            end else if (a == 8'hF4) begin
`ifdef TIMER_MC_PRESCALER_EN
                m_presc = longint'(d) & ((longint'(1) << PSW) - 1);
                pw = 1;
`endif
            end else if (ch < NCH && off == 0) begin
                m_en[ch] = d[0]; m_ie[ch] = d[1]; m_mode[ch] = d[3];
                if (d[2]) m_pend[ch] = 0;
            end else if (ch < NCH && off == 8) begin
                m_cmp[ch] = longint'(d) & CMASK;
            end
        end
        for (int i = 0; i < NCH; i++) if (hit[i]) m_pend[i] = 1;
        if (pw || !any || tk) m_psc = 0;
        else m_psc = m_psc + 1;
    endfunction

    // One bus cycle: predict outputs from pre-edge state, queue them, then clock the model.
    task automatic cyc(input bit w, input bit [31:0] a, input bit [31:0] d);
        exp_t e;
        we_i = w; addr_i = a; data_i = d;
        e.rd = m_read(a[7:0]);
        e.irq = m_irq();
        q.push_back(e);
        @(posedge clk);
        m_step(w, a[7:0], d);
        #1;
        we_i = 0;
    endtask

    task automatic wait_bit(input int b, input int limit, input bit [7:0] ra, output int n);
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc(0, {24'h0, ra}, 0);
            if (int_ch_o[b]) begin n = k; break; end
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("rdata", longint'(data_o), e.rd);
            check("int_ch", longint'(int_ch_o), longint'(e.irq));
            check("int_sig", longint'(int_sig_o), longint'(e.irq != 0));
        end
    end

    initial begin
        int n;
        bit [7:0] regs[] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h18, 8'h24, 8'h38, 8'h40, 8'hF0, 8'hF4};
        rst = 1; we_i = 0; addr_i = 0; data_i = 0;
        m_reset();
        @(posedge clk); #1;
        repeat (3) cyc(0, 32'h0, 0);
        rst = 0;
        foreach (regs[i]) cyc(0, {24'h0, regs[i]}, 0);
        check("reset_int", longint'(int_ch_o), 0);

        // One-shot ch0
        cyc(1, 32'h08, 5);
        cyc(1, 32'h00, 3);
        wait_bit(0, 20, 8'h04, n);
        check("oneshot_lat", n, 6);
        cyc(0, 32'h00, 0);
        cyc(1, 32'h00, 4);
        check("oneshot_w1c", longint'(int_sig_o), 0);

        // Periodic ch1
        cyc(1, 32'h18, 3);
        cyc(1, 32'h10, 32'hB);
        wait_bit(1, 10, 8'h14, n);
        check("period_first", n, 4);
        repeat (3) begin
            cyc(1, 32'h10, 32'hF);
            wait_bit(1, 10, 8'h10, n);
            check("period", n + 1, 4);
        end
        cyc(1, 32'h10, 32'hF);
        cyc(0, 32'h14, 0);
        cyc(0, 32'h14, 0);
        cyc(1, 32'h10, 32'hF);
        check("race_ctrl", longint'(int_ch_o[1]), 1);
        cyc(1, 32'h10, 32'hF);
        cyc(0, 32'h14, 0);
        cyc(0, 32'h14, 0);
        cyc(1, 32'hF0, 32'h2);
        check("race_status", longint'(int_ch_o[1]), 1);
        cyc(1, 32'h10, 32'h4);

        // Two channels with different compares
        cyc(1, 32'h08, 2);
        cyc(1, 32'h28, 4);
        cyc(1, 32'h00, 3);
        cyc(1, 32'h20, 3);
        repeat (3) cyc(0, 32'hF0, 0);
        check("multi_first", longint'(int_ch_o), 1);
        repeat (3) cyc(0, 32'hF0, 0);
        check("multi_both", longint'(int_ch_o), 5);
        cyc(0, 32'hF0, 0);
        cyc(1, 32'hF0, 5);
        check("multi_clr", longint'(int_ch_o), 0);

        // Prescaler (or its absence) with a one-shot on ch3
        cyc(1, 32'hF4, 3);
        cyc(1, 32'h38, 1);
        cyc(1, 32'h30, 3);
        wait_bit(3, 20, 8'hF4, n);
`ifdef TIMER_MC_PRESCALER_EN
        check("presc_lat", n, 8);
`else
        check("presc_lat", n, 2);
`endif
        cyc(1, 32'hF4, 0);
        cyc(1, 32'h30, 4);

        // Randomised traffic
        for (int k = 0; k < 600; k++) begin
            logic [7:0]  a;
            logic [31:0] d;
            logic        w;
            case ($urandom_range(0, 9))
                0: a = 8'($urandom_range(0, 255));
                1: a = 8'hF0;
                2: a = 8'hF4;
                default: a = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 3) << 2)};
            endcase
            w = ($urandom_range(0, 3) == 0);
            d = $urandom();
            if (a[3:0] == 4'h8) d = $urandom_range(0, 9);
            if (a == 8'hF4) d = $urandom_range(0, 3);
            cyc(w, {24'($urandom()), a}, d);
        end

        // Reset while channels may be running
        rst = 1;
        cyc(0, 32'h04, 0);
        rst = 0;
        check("midreset_int", longint'(int_ch_o), 0);
        foreach (regs[i]) cyc(0, {24'h0, regs[i]}, 0);

        check("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
